mem_write_buffer: RTL
=====================

Name: mem_write_buffer

Overview:
- Sits between the core memory port and the controller memory port; each core request is forwarded to the controller-side memory.
- Posts core writes into a small FIFO and acknowledges them early, so the core does not stall on write latency.
- Drains posted writes to memory in order; reads wait for the drain, which preserves memory ordering.
- Adds a per-transaction response timeout that keeps a hung memory side from locking the core forever.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- DEPTH, 4, posted-write FIFO entries; power of two, 2..16.
- TIMEOUT_CYCLES, 1024, cycles to wait for mem_response before abandoning a memory request.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- core_read  in  1  core read request, held until core_response.
- core_write  in  1  core write request, held until core_response.
- core_address  in  ADDR_WIDTH  request address.
- core_write_data  in  DATA_WIDTH  write data.
- core_read_data  out  DATA_WIDTH  read return data, valid while core_response=1.
- core_response  out  1  one-cycle completion pulse to core.
- mem_read  out  1  memory read request, held until mem_response.
- mem_write  out  1  memory write request, held until mem_response.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read_data  in  DATA_WIDTH  memory read data, sampled when mem_response=1.
- mem_response  in  1  one-cycle memory completion pulse.
- fifo_count  out  $clog2(DEPTH)+1  current posted-write occupancy.
- bus_error  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, active-high) clears to 0: all outputs, FIFO pointers, timeout counter, bus_error. State goes to IDLE.
- All outputs are registered.

New-request detection:
- A core request is "new" only when core_response was 0 in the previous cycle. This blocks re-acceptance of a request the core is still deasserting.
- If core_write and core_read are both high, the write wins and the read is ignored for that handshake.

Write path:
- New write with fifo_count<DEPTH: push {core_address, core_write_data}. core_response pulses the next cycle (1-cycle latency).
- FIFO full: the write stays pending, with no response until a slot frees. A pop and a push in the same cycle are allowed; the count is unchanged.

Drain (independent of core side):
- While the FIFO is non-empty and no memory request is outstanding, drive mem_write=1 with the head entry.
- Hold mem_write=1 until mem_response. On mem_response: pop, deassert mem_write for at least one cycle, then issue the next entry.

Read state machine:
- IDLE: a new read latches the address and goes to DRAIN.
- DRAIN: wait until fifo_count=0 and mem_write=0, then go to RD_ISSUE.
- RD_ISSUE: drive mem_read=1 with the latched address. On mem_response, capture mem_read_data and go to RD_DONE.
- RD_DONE: core_response=1 and core_read_data valid for exactly one cycle, then back to IDLE.
- Minimum read latency, empty FIFO and zero-wait memory: 3 cycles from core_read to core_response.
- Writes may be accepted while a read is in DRAIN? No: while the read FSM is not IDLE, new writes are not accepted.

Timeout:
- A counter starts when mem_read or mem_write asserts and resets on mem_response.
- Reaching TIMEOUT_CYCLES-1 without a response:
  - drop the request (write: pop entry; read: return DATA_WIDTH'hDEADBEEF truncated/zero-extended, go to RD_DONE);
  - set bus_error.
- A mem_response arriving while no memory request is outstanding is ignored.

Outputs:
- mem_address / mem_write_data hold their last values when idle.
- core_read_data holds its last value outside RD_DONE.

Optional Feature:
- Macro: MEM_WRITE_BUFFER_FORWARD_EN.
- Defined: a new read whose address equals any valid FIFO entry completes without DRAIN or a memory access. It returns the youngest matching entry's data, with core_response pulsing 1 cycle after the request. Non-matching reads behave as in the base design.
- Undefined: every read drains the FIFO first; no address comparators are built.

Test Plan:
- Single write, addr 0x10, data 0xA5A5A5A5, mem_response 2 cycles after mem_write -> core_response the cycle after core_write; mem_write with addr 0x10, data 0xA5A5A5A5; fifo_count 1 then 0.
- Five back-to-back writes with DEPTH=4, mem_response delayed 10 cycles -> first 4 acknowledged in consecutive handshakes; 5th waits until the first pop; memory sees all 5 in order.
- Write 0x20=0x11, then read 0x24; memory returns 0x22 -> mem_read asserts only after the write's mem_response; core_read_data=0x22.
- Read with mem_response never asserted, TIMEOUT_CYCLES=16 -> core_response with core_read_data=0xDEADBEEF; bus_error=1 and stays 1. A later stray mem_response is ignored.
- Reset asserted while mem_write is pending with 3 FIFO entries -> all outputs 0 immediately; fifo_count=0; no memory request after reset release.
- MEM_WRITE_BUFFER_FORWARD_EN: write 0x30=0x1, write 0x30=0x2, read 0x30 with memory stalled -> core_read_data=0x2; no mem_read issued.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the core memory port and the controller memory port.
// Latency: write ack 1 cycle after acceptance; read >= 3 cycles (drain + issue + done).
// Backpressure: a full FIFO or a busy read FSM holds the core request with no response.
// Optional store-to-load forwarding enabled by defining MEM_WRITE_BUFFER_FORWARD_EN.
module mem_write_buffer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_read,
    input  logic                    core_write,
    input  logic [ADDR_WIDTH-1:0]   core_address,
    input  logic [DATA_WIDTH-1:0]   core_write_data,
    output logic [DATA_WIDTH-1:0]   core_read_data,
    output logic                    core_response,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_response,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    bus_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] BAD_DATA = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RD_ISSUE, S_RD_DONE} rd_state_t;

    rd_state_t               state_q;
    logic [ADDR_WIDTH-1:0]   fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_data_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic [DATA_WIDTH-1:0]   mem_write_data_q;
    logic                    core_response_q;
    logic [DATA_WIDTH-1:0]   core_read_data_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [TW-1:0]           tmo_q;
    logic [TW-1:0]           tmo_d;
    logic                    bus_error_q;

    logic                    mem_busy;
    logic                    tmo_hit;
    logic                    pop;
    logic                    rd_done;
    logic                    push;
    logic                    new_read;
    logic                    issue_wr;
    logic                    fwd_hit;
    logic [DATA_WIDTH-1:0]   fwd_data;

    // Handshake decode: a request is only new once the previous response has gone away,
    // so a core still holding its request after the ack is not accepted twice.
    always_comb begin
        mem_busy = mem_read_q | mem_write_q;
        tmo_hit  = mem_busy & ~mem_response & (tmo_q == TMO_LAST);
        pop      = mem_write_q & (mem_response | tmo_hit);
        rd_done  = mem_read_q & (mem_response | tmo_hit);
        // Writes win over reads; a full FIFO may still take a push in the cycle it pops.
        push     = core_write & ~core_response_q & (state_q == S_IDLE)
                 & ((count_q != CW'(DEPTH)) | pop);
        new_read = core_read & ~core_write & ~core_response_q & (state_q == S_IDLE);
        issue_wr = ~mem_busy & (count_q != '0);
        count_d  = count_q + CW'(push) - CW'(pop);
        // The timeout counter runs only while a memory request is waiting.
        tmo_d    = (mem_busy & ~mem_response & ~tmo_hit) ? tmo_q + TW'(1) : '0;
    end

`ifdef MEM_WRITE_BUFFER_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Search valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (fifo_addr_q[fwd_idx] == core_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[fwd_idx];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // FIFO storage needs no reset: entries are only read while the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= core_address;
            fifo_data_q[wr_ptr_q] <= core_write_data;
        end
    end

    // Control: FIFO pointers, drain engine, read FSM and timeout, all with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            core_response_q  <= 1'b0;
            core_read_data_q <= '0;
            rd_addr_q        <= '0;
            tmo_q            <= '0;
            bus_error_q      <= 1'b0;
        end else begin
            core_response_q <= push;
            count_q         <= count_d;
            tmo_q           <= tmo_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (tmo_hit) bus_error_q <= 1'b1;

            // Drain: one write in flight; dropping mem_write after a completion
            // guarantees a one-cycle gap before the next entry goes out.
            if (pop) begin
                mem_write_q <= 1'b0;
            end else if (issue_wr) begin
                mem_write_q      <= 1'b1;
                mem_address_q    <= fifo_addr_q[rd_ptr_q];
                mem_write_data_q <= fifo_data_q[rd_ptr_q];
            end

            case (state_q)
                S_IDLE: begin
                    if (new_read) begin
                        if (fwd_hit) begin
                            core_response_q  <= 1'b1;
                            core_read_data_q <= fwd_data;
                        end else begin
                            rd_addr_q <= core_address;
                            state_q   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Older posted writes must reach memory before the read.
                    if ((count_q == '0) && !mem_write_q) begin
                        mem_read_q    <= 1'b1;
                        mem_address_q <= rd_addr_q;
                        state_q       <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    if (rd_done) begin
                        mem_read_q       <= 1'b0;
                        core_response_q  <= 1'b1;
                        core_read_data_q <= mem_response ? mem_read_data : BAD_DATA;
                        state_q          <= S_RD_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_read_data = core_read_data_q;
    assign core_response  = core_response_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign fifo_count     = count_q;
    assign bus_error      = bus_error_q;

endmodule
